ldpc_frame_loader: RTL and testbench

- Parametrised successor to the LDPC test-harness front end.
- Collects quantised LLR samples from NCH independent noise/quantiser channels over valid/ready handshakes into per-channel fill buffers.
- Loads a complete frame into the decoder, waits for decoder termination, then scores the hard decisions against the all-zero codeword.
- Fill buffers are decoupled from the decoder input register, so the next frame fills while the current one decodes. Accumulates bit/frame error statistics over a programmed frame count.

---
 rtl/ldpc_intf_pkg.sv | 26 ++
 rtl/ldpc_popcnt.sv | 48 ++++
 rtl/ldpc_frame_loader.sv | 244 ++++++++++++++++++++++++
 tb/tb_ldpc_frame_loader.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_intf_pkg.sv
// Shared state encoding and width helpers for the LDPC frame loader.
// POP_W is the popcount width of the default 128x18 codeword.
package ldpc_intf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LOAD,
        S_DECODE,
        S_SCORE,
        S_DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    localparam int DIM_DEF = 128 * 18;
    localparam int POP_W   = clog2(DIM_DEF + 1);

endpackage

// File: rtl/ldpc_popcnt.sv
// Registered-output popcount: balanced adder tree over N bits, 1-cycle latency.
// The result register only loads while en_i is high.
module ldpc_popcnt
    import ldpc_intf_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [N-1:0] bits_i,
    output logic [W-1:0] pop_o
);

    localparam int L  = clog2(N);
    localparam int NP = 1 << L;

    // Heap-ordered tree: node k sums children 2k and 2k+1, root at 1.
    function automatic logic [W-1:0] tree_sum(input logic [N-1:0] b);
        logic [W-1:0] node [1:2*NP-1];
        for (int i = 0; i < N; i++) begin
            node[NP+i] = W'(b[i]);
        end
        for (int i = N; i < NP; i++) begin
            node[NP+i] = '0;
        end
        for (int i = NP - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
        return node[1];
    endfunction

    logic [W-1:0] pop_d;
    logic [W-1:0] pop_q;

    assign pop_d = tree_sum(bits_i);
    assign pop_o = pop_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pop_q <= '0;
        end else if (en_i) begin
            pop_q <= pop_d;
        end
    end

endmodule

// File: rtl/ldpc_frame_loader.sv
// LDPC harness front end: fills per-channel LLR buffers, loads/decodes/scores frames.
// Define LDPC_DEC_TIMEOUT_EN for a MAX_CYC decode timeout and the timeouts port.
module ldpc_frame_loader
    import ldpc_intf_pkg::*;
#(
    parameter int DATA_W  = 5,
    parameter int NCH     = 128,
    parameter int PER_CH  = 18,
    parameter int FRM_W   = 16,
`ifdef LDPC_DEC_TIMEOUT_EN
    parameter int ERR_W   = 32,
    parameter int MAX_CYC = 1024
`else
    parameter int ERR_W   = 32
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [FRM_W-1:0]               num_frames,
    input  logic [NCH*DATA_W-1:0]          llr_in,
    input  logic [NCH-1:0]                 llr_valid,
    output logic [NCH-1:0]                 llr_ready,
    output logic [NCH*PER_CH*DATA_W-1:0]   dec_llr,
    output logic                           dec_en,
    output logic                           dec_rst,
    input  logic [NCH*PER_CH-1:0]          dec_res,
    input  logic                           dec_term,
    output logic [FRM_W-1:0]               frame_cnt,
    output logic [ERR_W-1:0]               err_bits,
    output logic [FRM_W-1:0]               err_frames,
`ifdef LDPC_DEC_TIMEOUT_EN
    output logic [FRM_W-1:0]               timeouts,
`endif
    output logic                           busy,
    output logic                           done
);

    localparam int DIM = NCH * PER_CH;
    localparam int PW  = clog2(DIM + 1);
    localparam int CW  = clog2(PER_CH + 1);
    localparam int SW  = ((ERR_W > PW) ? ERR_W : PW) + 1;
`ifdef LDPC_DEC_TIMEOUT_EN
    localparam int YW  = clog2(MAX_CYC + 1);
`endif

    state_t                  state_q;
    logic [FRM_W-1:0]        nfr_q;
    logic [FRM_W-1:0]        frame_cnt_q;
    logic [FRM_W-1:0]        err_frames_q;
    logic [ERR_W-1:0]        err_bits_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    dec_en_q;
    logic                    dec_rst_q;
    logic                    guard_q;
    logic                    phase_q;
    logic [DIM*DATA_W-1:0]   buf_q;
    logic [DIM*DATA_W-1:0]   dec_llr_q;
    logic [CW-1:0]           fill_cnt_q [NCH];
`ifdef LDPC_DEC_TIMEOUT_EN
    logic [YW-1:0]           cyc_q;
    logic [FRM_W-1:0]        timeouts_q;
`endif

    logic [NCH-1:0]          full;
    logic [NCH-1:0]          ready;
    logic [PW-1:0]           pop;
    logic                    all_full;
    logic                    start_go;
    logic                    last_frame;
    logic                    load_go;
    logic                    pop_en;
    logic [SW-1:0]           err_sum;

    always_comb begin
        full = '0;
        for (int i = 0; i < NCH; i++) begin
            full[i] = (fill_cnt_q[i] == CW'(PER_CH));
        end
        all_full   = &full;
        ready      = (busy_q && state_q != S_LOAD) ? ~full : '0;
        start_go   = start && (state_q == S_IDLE || state_q == S_DONE);
        last_frame = (frame_cnt_q + FRM_W'(1)) == nfr_q;
        load_go    = all_full && (state_q == S_FILL ||
                     (state_q == S_SCORE && phase_q && !last_frame));
        pop_en     = (state_q == S_SCORE) && !phase_q;
        err_sum    = SW'(err_bits_q) + SW'(pop);
    end

    ldpc_popcnt #(
        .N (DIM),
        .W (PW)
    ) u_popcnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (pop_en),
        .bits_i (dec_res),
        .pop_o  (pop)
    );

    // Fill buffers run independently of the FSM so filling overlaps decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                fill_cnt_q[i] <= '0;
            end
        end else if (start_go) begin
            buf_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                fill_cnt_q[i] <= '0;
            end
        end else if (load_go) begin
            for (int i = 0; i < NCH; i++) begin
                fill_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (llr_valid[i] && ready[i]) begin
                    buf_q[(i*PER_CH + int'(fill_cnt_q[i]))*DATA_W +: DATA_W]
                        <= llr_in[i*DATA_W +: DATA_W];
                    fill_cnt_q[i] <= fill_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            nfr_q        <= '0;
            frame_cnt_q  <= '0;
            err_frames_q <= '0;
            err_bits_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dec_en_q     <= 1'b0;
            dec_rst_q    <= 1'b0;
            guard_q      <= 1'b0;
            phase_q      <= 1'b0;
            dec_llr_q    <= '0;
`ifdef LDPC_DEC_TIMEOUT_EN
            cyc_q        <= '0;
            timeouts_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        nfr_q        <= num_frames;
                        frame_cnt_q  <= '0;
                        err_bits_q   <= '0;
                        err_frames_q <= '0;
`ifdef LDPC_DEC_TIMEOUT_EN
                        timeouts_q   <= '0;
`endif
                        if (num_frames == '0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            state_q <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (all_full) begin
                        dec_llr_q <= buf_q;
                        dec_rst_q <= 1'b1;
                        dec_en_q  <= 1'b1;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dec_rst_q <= 1'b0;
                    guard_q   <= 1'b1;
`ifdef LDPC_DEC_TIMEOUT_EN
                    cyc_q     <= '0;
`endif
                    state_q   <= S_DECODE;
                end
                S_DECODE: begin
                    // The first DECODE cycle may still see the previous term.
                    guard_q <= 1'b0;
                    if (!guard_q && dec_term) begin
                        dec_en_q <= 1'b0;
                        phase_q  <= 1'b0;
                        state_q  <= S_SCORE;
`ifdef LDPC_DEC_TIMEOUT_EN
                    end else if (cyc_q == YW'(MAX_CYC - 1)) begin
                        dec_en_q   <= 1'b0;
                        phase_q    <= 1'b0;
                        timeouts_q <= timeouts_q + FRM_W'(1);
                        state_q    <= S_SCORE;
                    end else begin
                        cyc_q <= cyc_q + YW'(1);
`endif
                    end
                end
                S_SCORE: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q      <= 1'b0;
                        frame_cnt_q  <= frame_cnt_q + FRM_W'(1);
                        err_frames_q <= err_frames_q + FRM_W'(pop != '0);
                        err_bits_q   <= (|err_sum[SW-1:ERR_W]) ? '1
                                        : err_sum[ERR_W-1:0];
                        if (last_frame) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (all_full) begin
                            dec_llr_q <= buf_q;
                            dec_rst_q <= 1'b1;
                            dec_en_q  <= 1'b1;
                            state_q   <= S_LOAD;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign llr_ready  = ready;
    assign dec_llr    = dec_llr_q;
    assign dec_en     = dec_en_q;
    assign dec_rst    = dec_rst_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_bits   = err_bits_q;
    assign err_frames = err_frames_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef LDPC_DEC_TIMEOUT_EN
    assign timeouts   = timeouts_q;
`endif

endmodule

// File: tb/tb_ldpc_frame_loader.sv
// Scoreboard bench for ldpc_frame_loader with a small behavioural decoder.
// Build with LDPC_DEC_TIMEOUT_EN to also exercise the decode timeout.
module tb_ldpc_frame_loader;

    localparam int DATA_W = 5;
    localparam int NCH    = 2;
    localparam int PER_CH = 3;
    localparam int DIM    = NCH * PER_CH;
    localparam int FRM_W  = 8;
    localparam int ERR_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [FRM_W-1:0]         num_frames;
    logic [NCH*DATA_W-1:0]    llr_in;
    logic [NCH-1:0]           llr_valid;
    logic [NCH-1:0]           llr_ready;
    logic [DIM*DATA_W-1:0]    dec_llr;
    logic                     dec_en;
    logic                     dec_rst;
    logic [DIM-1:0]           dec_res;
    logic                     dec_term;
    logic [FRM_W-1:0]         frame_cnt;
    logic [ERR_W-1:0]         err_bits;
    logic [FRM_W-1:0]         err_frames;
    logic                     busy;
    logic                     done;
`ifdef LDPC_DEC_TIMEOUT_EN
    logic [FRM_W-1:0]         timeouts;
`endif

    always #5 clk = ~clk;

    ldpc_frame_loader #(
        .DATA_W (DATA_W),
        .NCH    (NCH),
        .PER_CH (PER_CH),
        .FRM_W  (FRM_W),
`ifdef LDPC_DEC_TIMEOUT_EN
        .ERR_W  (ERR_W),
        .MAX_CYC(8)
`else
        .ERR_W  (ERR_W)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_frames (num_frames),
        .llr_in     (llr_in),
        .llr_valid  (llr_valid),
        .llr_ready  (llr_ready),
        .dec_llr    (dec_llr),
        .dec_en     (dec_en),
        .dec_rst    (dec_rst),
        .dec_res    (dec_res),
        .dec_term   (dec_term),
        .frame_cnt  (frame_cnt),
        .err_bits   (err_bits),
        .err_frames (err_frames),
`ifdef LDPC_DEC_TIMEOUT_EN
        .timeouts   (timeouts),
`endif
        .busy       (busy),
        .done       (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int src_idx  [NCH];
    int src_tot  [NCH];
    int src_gate [NCH];

    logic [DIM*DATA_W-1:0] exp_q [$];
    logic [DIM*DATA_W-1:0] exp_v;
    logic [DIM-1:0]        res_q [$];
    int                    en_lens [$];

    int term_delay  = 5;
    bit term_hold   = 0;
    int never_after = 1000;
    int n_rst       = 0;
    int dec_cnt     = 0;
    int en_len      = 0;

    function automatic logic [DATA_W-1:0] smp(input int c, input int k);
        return DATA_W'(c * 16 + k + 1);
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (llr_valid[c] && llr_ready[c]) src_idx[c]++;
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (src_gate[c] > 0) src_gate[c]--;
            llr_valid[c] = (src_idx[c] < src_tot[c]) && (src_gate[c] == 0);
            llr_in[c*DATA_W +: DATA_W] = smp(c, src_idx[c]);
        end
    end

    // Behavioural decoder: checks each loaded frame, then terminates.
    always @(negedge clk) begin
        if (!rst && dec_rst) begin
            n_rst++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL frame_data: unexpected load %h", dec_llr);
            end else begin
                exp_v = exp_q.pop_front();
                if (dec_llr !== exp_v) begin
                    n_bad++;
                    $display("FAIL frame_data: got %h want %h", dec_llr, exp_v);
                end
            end
            dec_res  = (res_q.size() > 0) ? res_q.pop_front() : '0;
            dec_cnt  = 0;
            en_len   = 1;
            dec_term = term_hold;
        end else if (!rst) begin
            dec_cnt++;
            if (dec_en) begin
                en_len++;
            end else if (en_len > 0) begin
                en_lens.push_back(en_len);
                en_len = 0;
            end
            if (term_hold) dec_term = dec_en;
            else dec_term = (dec_cnt == term_delay) && (n_rst - 1 < never_after);
        end
    end

    task automatic prep(input int nf, input int delay, input bit hold, input int never);
        logic [DIM*DATA_W-1:0] v;
        exp_q.delete();
        res_q.delete();
        en_lens.delete();
        n_rst       = 0;
        en_len      = 0;
        dec_term    = 1'b0;
        term_delay  = delay;
        term_hold   = hold;
        never_after = never;
        for (int c = 0; c < NCH; c++) begin
            src_idx[c] = 0;
            src_tot[c] = nf * PER_CH;
        end
        for (int f = 0; f < nf; f++) begin
            v = '0;
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < PER_CH; k++)
                    v[(c*PER_CH+k)*DATA_W +: DATA_W] = smp(c, f*PER_CH + k);
            exp_q.push_back(v);
        end
    endtask

    task automatic kick(input int nf);
        @(negedge clk);
        num_frames = FRM_W'(nf);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        num_frames = '0;
        dec_term = 1'b0;
        dec_res = '0;
        for (int c = 0; c < NCH; c++) begin
            src_idx[c] = 0;
            src_tot[c] = 0;
            src_gate[c] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, dec_en, dec_rst, llr_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 0", {busy, done, dec_en, dec_rst, llr_ready});
        end
        n_cmp++;
        if ({frame_cnt, err_bits, err_frames} !== '0) begin
            n_bad++;
            $display("FAIL reset_stats: got %h want 0", {frame_cnt, err_bits, err_frames});
        end
        n_cmp++;
        if (dec_llr !== '0) begin
            n_bad++;
            $display("FAIL reset_llr: got %h want 0", dec_llr);
        end
`ifdef LDPC_DEC_TIMEOUT_EN
        n_cmp++;
        if (timeouts !== '0) begin
            n_bad++;
            $display("FAIL reset_timeouts: got %0d want 0", timeouts);
        end
`endif
    endtask

    task automatic test_single();
        bit ok;
        int lat;
        prep(1, 5, 0, 1000);
        @(negedge clk);
        kick(1);
        lat = 0;
        while (!dec_rst && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != PER_CH + 1) begin
            n_bad++;
            $display("FAIL single_latency: got %0d want %0d", lat, PER_CH + 1);
        end
        wait_done(200, ok);
        n_cmp++;
        if (!ok || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: done %0d busy %b want done 1 busy 0", ok, busy);
        end
        n_cmp++;
        if (frame_cnt !== 8'd1 || err_bits !== 4'd0 || err_frames !== 8'd0) begin
            n_bad++;
            $display("FAIL single_stats: got %0d/%0d/%0d want 1/0/0", frame_cnt, err_bits, err_frames);
        end
        n_cmp++;
        if (n_rst != 1 || en_lens.size() != 1 || en_lens[0] != 6) begin
            n_bad++;
            $display("FAIL single_pulses: rst %0d en_len %0d want 1 and 6", n_rst,
                     (en_lens.size() > 0) ? en_lens[0] : -1);
        end
    endtask

    task automatic test_multi_frame();
        bit ok;
        prep(3, 4, 0, 1000);
        res_q.push_back(6'b000000);
        res_q.push_back(6'b001111);
        res_q.push_back(6'b000000);
        @(negedge clk);
        kick(3);
        for (int t = 0; t < 100 && n_rst < 1; t++) @(negedge clk);
        @(negedge clk);
        num_frames = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL multi_done: done never seen");
        end
        n_cmp++;
        if (frame_cnt !== 8'd3 || err_bits !== 4'd4 || err_frames !== 8'd1) begin
            n_bad++;
            $display("FAIL multi_stats: got %0d/%0d/%0d want 3/4/1", frame_cnt, err_bits, err_frames);
        end
        n_cmp++;
        if (n_rst != 3 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL multi_loads: got %0d loads %0d left want 3/0", n_rst, exp_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad_rdy;
        int bad_ld;
        src_gate[1] = 20;
        prep(2, 3, 0, 1000);
        kick(2);
        repeat (5) @(negedge clk);
        bad_rdy = 0;
        bad_ld = 0;
        repeat (10) begin
            @(negedge clk);
            if (llr_ready[0] !== 1'b0) bad_rdy++;
            if (dec_rst !== 1'b0 || dec_en !== 1'b0) bad_ld++;
        end
        n_cmp++;
        if (bad_rdy != 0) begin
            n_bad++;
            $display("FAIL stall_ready0: got %0d ready cycles want 0", bad_rdy);
        end
        n_cmp++;
        if (bad_ld != 0 || n_rst != 0) begin
            n_bad++;
            $display("FAIL stall_noload: got %0d busy cycles %0d loads want 0/0", bad_ld, n_rst);
        end
        wait_done(400, ok);
        n_cmp++;
        if (!ok || frame_cnt !== 8'd2 || n_rst != 2) begin
            n_bad++;
            $display("FAIL stall_done: done %0d frames %0d loads %0d want 1/2/2", ok, frame_cnt, n_rst);
        end
        n_cmp++;
        if (src_idx[0] != 6 || src_idx[1] != 6) begin
            n_bad++;
            $display("FAIL stall_count: got %0d/%0d want 6/6", src_idx[0], src_idx[1]);
        end
    endtask

    task automatic test_term_hold();
        bit ok;
        prep(2, 0, 1, 1000);
        kick(2);
        wait_done(300, ok);
        n_cmp++;
        if (!ok || frame_cnt !== 8'd2 || n_rst != 2) begin
            n_bad++;
            $display("FAIL hold_frames: done %0d frames %0d loads %0d want 1/2/2", ok, frame_cnt, n_rst);
        end
        n_cmp++;
        if (en_lens.size() != 2 || en_lens[0] != 3 || en_lens[1] != 3) begin
            n_bad++;
            $display("FAIL hold_guard: got %0d windows first %0d want 2 of 3",
                     en_lens.size(), (en_lens.size() > 0) ? en_lens[0] : -1);
        end
        term_hold = 0;
        dec_term = 1'b0;
    endtask

    task automatic test_saturate();
        bit ok;
        prep(3, 2, 0, 1000);
        repeat (3) res_q.push_back(6'b111111);
        kick(3);
        wait_done(400, ok);
        n_cmp++;
        if (!ok || err_bits !== 4'd15 || err_frames !== 8'd3) begin
            n_bad++;
            $display("FAIL sat_bits: got %0d/%0d want 15/3", err_bits, err_frames);
        end
    endtask

    task automatic test_zero_frames();
        prep(0, 2, 0, 1000);
        kick(0);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || frame_cnt !== '0 || err_bits !== '0) begin
            n_bad++;
            $display("FAIL zero_frames: done %b busy %b frames %0d err %0d want 1/0/0/0",
                     done, busy, frame_cnt, err_bits);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (n_rst != 0 || dec_en !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_noload: got %0d loads want 0", n_rst);
        end
    endtask

    task automatic test_reset_mid();
        prep(2, 3, 0, 1);
        res_q.push_back(6'b000011);
        kick(2);
        for (int t = 0; t < 200 && n_rst < 2; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (frame_cnt !== 8'd1 || err_bits !== 4'd2 || dec_en !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: frames %0d err %0d en %b want 1/2/1", frame_cnt, err_bits, dec_en);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dec_en, dec_rst, busy, done, llr_ready} !== '0 ||
            {frame_cnt, err_bits, err_frames} !== '0 || dec_llr !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: ctl %b stats %h want all 0",
                     {dec_en, dec_rst, busy, done, llr_ready}, {frame_cnt, err_bits, err_frames});
        end
        @(negedge clk);
        rst = 1'b0;
        src_tot[0] = 0;
        src_tot[1] = 0;
        @(negedge clk);
    endtask

`ifdef LDPC_DEC_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        prep(1, 3, 0, 0);
        res_q.push_back(6'b000101);
        kick(1);
        wait_done(200, ok);
        n_cmp++;
        if (!ok || timeouts !== 8'd1 || frame_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL timeout_cnt: done %0d timeouts %0d frames %0d want 1/1/1", ok, timeouts, frame_cnt);
        end
        n_cmp++;
        if (err_bits !== 4'd2 || en_lens.size() != 1 || en_lens[0] != 9) begin
            n_bad++;
            $display("FAIL timeout_len: err %0d en_len %0d want 2 and 9",
                     err_bits, (en_lens.size() > 0) ? en_lens[0] : -1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_multi_frame();
        test_stall();
        test_term_hold();
        test_saturate();
        test_zero_frames();
        test_reset_mid();
`ifdef LDPC_DEC_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
